gf2m_trinomial_reduce: RTL and testbench

//   Downstream consumer of the 409x409 binary-field (GF(2)[x]) multiplier.

---
 rtl/gf2m_pkg.sv | 18 +
 rtl/gf2m_fold.sv | 16 +
 rtl/gf2m_trinomial_reduce.sv | 100 ++++++++++
 tb/tb_gf2m_trinomial_reduce.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared constants, state encoding and fold-count helper for the GF(2^m) trinomial reducer.
package gf2m_pkg;

  localparam int GF2M_M = 409;
  localparam int GF2M_K = 87;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Each fold lowers the degree bound by at least M-K; ceil((M-1)/(M-K)) folds clear the upper half.
  function automatic int nfold(input int m, input int k);
    return ((m - 1) + (m - k) - 1) / (m - k);
  endfunction

endpackage

// File: rtl/gf2m_fold.sv
// One combinational fold of a 2*M-bit polynomial modulo x^M + x^K + 1.
module gf2m_fold #(
  parameter int M = 409,
  parameter int K = 87
) (
  input  logic [2*M-1:0] a_i,
  output logic [2*M-1:0] a_o
);

  logic [2*M-1:0] hi;

  // x^M == x^K + 1, so the upper half folds back in at offsets 0 and K.
  assign hi  = {{M{1'b0}}, a_i[2*M-1:M]};
  assign a_o = {{M{1'b0}}, a_i[M-1:0]} ^ hi ^ (hi << K);

endmodule

// File: rtl/gf2m_trinomial_reduce.sv
// Iterative reducer of a 2*M-bit carry-less product modulo x^M + x^K + 1.
// Build option REDUCE_CNT_EN adds the red_cnt completed-reduction counter port.
module gf2m_trinomial_reduce
  import gf2m_pkg::*;
#(
  parameter int M = GF2M_M,
  parameter int K = GF2M_K
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] c_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   r_out
`ifdef REDUCE_CNT_EN
  ,
  output logic [31:0]    red_cnt
`endif
);

  localparam int NFOLD = nfold(M, K);
  localparam int CW = $clog2(NFOLD) + 1;
  localparam logic [CW-1:0] LAST_FOLD = CW'(NFOLD - 1);

  state_e         state_q;
  logic [2*M-1:0] acc_q;
  logic [2*M-1:0] acc_d;
  logic [CW-1:0]  fold_cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [M-1:0]   r_out_q;

  gf2m_fold #(.M(M), .K(K)) u_fold (
    .a_i (acc_q),
    .a_o (acc_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      fold_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_out_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q      <= c_in;
            fold_cnt_q <= '0;
            in_ready_q <= 1'b0;
            state_q    <= FOLD;
          end
        end
        FOLD: begin
          acc_q      <= acc_d;
          fold_cnt_q <= fold_cnt_q + CW'(1);
          // Result is captured on the last fold so out_valid rises entering DONE.
          if (fold_cnt_q == LAST_FOLD) begin
            out_valid_q <= 1'b1;
            r_out_q     <= acc_d[M-1:0];
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r_out     = r_out_q;

`ifdef REDUCE_CNT_EN
  logic [31:0] red_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      red_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      red_cnt_q <= red_cnt_q + 32'd1;
    end
  end

  assign red_cnt = red_cnt_q;
`endif

endmodule

// File: tb/tb_gf2m_trinomial_reduce.sv
// Scoreboard bench for gf2m_trinomial_reduce; honours REDUCE_CNT_EN for the red_cnt port.
module tb_gf2m_trinomial_reduce;

  localparam int M = 409;
  localparam int K = 87;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*M-1:0] c_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [M-1:0]   r_out;
`ifdef REDUCE_CNT_EN
  logic [31:0]    red_cnt;
  int unsigned    exp_cnt = 0;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  logic [M-1:0] exp_q[$];
  bit           rdy_rand = 1'b0;
  logic         rdy_val = 1'b1;

  always #5 clk = ~clk;

  gf2m_trinomial_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out)
`ifdef REDUCE_CNT_EN
    ,
    .red_cnt   (red_cnt)
`endif
  );

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: schoolbook long division by x^M + x^K + 1, top bit downwards.
  function automatic logic [M-1:0] ref_mod(input logic [2*M-1:0] c);
    logic [2*M-1:0] r;
    r = c;
    for (int i = 2*M-1; i >= M; i--) begin
      if (r[i]) begin
        r[i]         = 1'b0;
        r[i - M + K] = ~r[i - M + K];
        r[i - M]     = ~r[i - M];
      end
    end
    return r[M-1:0];
  endfunction

  function automatic logic [2*M-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (a[i]) p = p ^ ({{M{1'b0}}, b} << i);
    return p;
  endfunction

  function automatic logic [2*M-1:0] rand_wide();
    logic [831:0] t;
    for (int j = 0; j < 26; j++) t[j*32 +: 32] = $urandom;
    return t[2*M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [2*M-1:0] t;
    t = rand_wide();
    return t[M-1:0];
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Monitor: a handshake seen between edges completes on the next posedge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h want none", r_out);
      end else begin
        check("r_out", r_out, exp_q.pop_front());
      end
`ifdef REDUCE_CNT_EN
      exp_cnt++;
`endif
    end
  end

  task automatic send(input logic [2*M-1:0] c, input logic [M-1:0] e);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    c_in     = c;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_pending", M'(exp_q.size()), M'(0));
  endtask

  task automatic wait_valid();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("wait_out_valid", M'(out_valid), M'(1));
  endtask

  initial begin
    logic [2*M-1:0] c;
    logic [M-1:0]   e;
    int             lat;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", M'(in_ready), M'(1));
    check("reset_out_valid", M'(out_valid), M'(0));
    check("reset_r_out", r_out, '0);
`ifdef REDUCE_CNT_EN
    check("reset_red_cnt", M'(red_cnt), M'(0));
`endif

    // x^409 -> x^87 + 1, with latency and busy in_ready checks
    c = '0; c[409] = 1'b1;
    e = '0; e[87] = 1'b1; e[0] = 1'b1;
    send(c, e);
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (lat == 1) check("busy_in_ready", M'(in_ready), M'(0));
      if (out_valid) break;
    end
    check("latency", M'(lat), M'(3));
    drain();

    // x^817 -> x^408 + x^173 + x^86
    c = '0; c[817] = 1'b1;
    e = '0; e[408] = 1'b1; e[173] = 1'b1; e[86] = 1'b1;
    send(c, e);
    drain();

    // already reduced input passes through
    c = '0; c[15:0] = 16'h1234;
    e = '0; e[15:0] = 16'h1234;
    send(c, e);
    drain();

    // randomized products plus some full-width words, random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 == 0) c = rand_wide();
      else            c = clmul(rand_elem(), rand_elem());
      send(c, ref_mod(c));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();
    rdy_rand = 1'b0;

    // stall in DONE: output stable, pending request not taken
    rdy_val = 1'b0;
    repeat (2) @(posedge clk);
    c = rand_wide();
    e = ref_mod(c);
    send(c, e);
    wait_valid();
    in_valid = 1'b1;
    c_in     = rand_wide();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", M'(out_valid), M'(1));
      check("stall_r_out", r_out, e);
      check("stall_in_ready", M'(in_ready), M'(0));
    end
    in_valid = 1'b0;
    rdy_val  = 1'b1;
    drain();
    repeat (6) @(negedge clk);
    check("no_pending_take_valid", M'(out_valid), M'(0));
    check("no_pending_take_ready", M'(in_ready), M'(1));

    // reset during FOLD discards the operation
    c = rand_wide();
    send(c, ref_mod(c));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
`ifdef REDUCE_CNT_EN
    exp_cnt = 0;
    check("midreset_red_cnt", M'(red_cnt), M'(0));
`endif
    check("midreset_out_valid", M'(out_valid), M'(0));
    check("midreset_in_ready", M'(in_ready), M'(1));
    repeat (5) @(negedge clk);
    check("midreset_no_output", M'(out_valid), M'(0));
    c = clmul(rand_elem(), rand_elem());
    send(c, ref_mod(c));
    drain();
`ifdef REDUCE_CNT_EN
    check("final_red_cnt", M'(red_cnt), M'(exp_cnt));
    check("final_red_cnt_one", M'(red_cnt), M'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
